// File: rtl/mc_arm_pkg.sv
// Shared definitions for the ARM multicycle control unit: FSM states,
// ALU operation codes, instruction field constants and datapath select
// encodings.
package mc_arm_pkg;

    typedef enum logic [3:0] {
        FETCH,
        DECODE,
        MEMADR,
        MEMRD,
        MEMWB,
        MEMWR,
        EXECR,
        EXECI,
        ALUWB,
        BRANCH,
        MULEX,
        MULWB,
        UNKNOWN
    } state_t;

    // ALUControl encodings
    localparam logic [2:0] ALU_ADD   = 3'b000;
    localparam logic [2:0] ALU_SUB   = 3'b001;
    localparam logic [2:0] ALU_AND   = 3'b010;
    localparam logic [2:0] ALU_ORR   = 3'b011;
    localparam logic [2:0] ALU_MUL   = 3'b100;
    localparam logic [2:0] ALU_UMULL = 3'b101;
    localparam logic [2:0] ALU_SMULL = 3'b110;

    // Data-processing cmd field Instr[24:21]
    localparam logic [3:0] CMD_AND = 4'b0000;
    localparam logic [3:0] CMD_SUB = 4'b0010;
    localparam logic [3:0] CMD_ADD = 4'b0100;
    localparam logic [3:0] CMD_CMP = 4'b1010;
    localparam logic [3:0] CMD_ORR = 4'b1100;

    // Multiply sub-opcode Instr[23:21]
    localparam logic [2:0] MUL_OP_MUL   = 3'b000;
    localparam logic [2:0] MUL_OP_UMULL = 3'b100;
    localparam logic [2:0] MUL_OP_SMULL = 3'b110;

    // Op field Instr[27:26]
    localparam logic [1:0] OP_DP  = 2'b00;
    localparam logic [1:0] OP_MEM = 2'b01;
    localparam logic [1:0] OP_BR  = 2'b10;

    // Condition codes Instr[31:28]
    localparam logic [3:0] COND_EQ = 4'b0000;
    localparam logic [3:0] COND_NE = 4'b0001;
    localparam logic [3:0] COND_CS = 4'b0010;
    localparam logic [3:0] COND_CC = 4'b0011;
    localparam logic [3:0] COND_MI = 4'b0100;
    localparam logic [3:0] COND_PL = 4'b0101;
    localparam logic [3:0] COND_VS = 4'b0110;
    localparam logic [3:0] COND_VC = 4'b0111;
    localparam logic [3:0] COND_HI = 4'b1000;
    localparam logic [3:0] COND_LS = 4'b1001;
    localparam logic [3:0] COND_GE = 4'b1010;
    localparam logic [3:0] COND_LT = 4'b1011;
    localparam logic [3:0] COND_GT = 4'b1100;
    localparam logic [3:0] COND_LE = 4'b1101;
    localparam logic [3:0] COND_AL = 4'b1110;

    // Bit positions inside the {N,Z,C,V} flag vector
    localparam int unsigned FLAG_N = 3;
    localparam int unsigned FLAG_Z = 2;
    localparam int unsigned FLAG_C = 1;
    localparam int unsigned FLAG_V = 0;

    // Datapath select encodings
    localparam logic [1:0] SRCA_A         = 2'b00;
    localparam logic [1:0] SRCA_PC        = 2'b01;
    localparam logic [1:0] SRCB_WD        = 2'b00;
    localparam logic [1:0] SRCB_IMM       = 2'b01;
    localparam logic [1:0] SRCB_FOUR      = 2'b10;
    localparam logic [1:0] RES_ALUOUT     = 2'b00;
    localparam logic [1:0] RES_DATA       = 2'b01;
    localparam logic [1:0] RES_ALURESULT  = 2'b10;
    localparam logic [1:0] IMM_8          = 2'b00;
    localparam logic [1:0] IMM_12         = 2'b01;
    localparam logic [1:0] IMM_24         = 2'b10;

    // Registered per-state control word
    typedef struct packed {
        logic       pc_write;
        logic       mem_write;
        logic       reg_write;
        logic       reg_write64;
        logic       ir_write;
        logic       adr_src;
        logic       reg_src64b;
        logic [1:0] alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] result_src;
        logic [2:0] alu_control;
    } ctrl_t;

    localparam ctrl_t CTRL_FETCH = '{
        pc_write:    1'b1,
        mem_write:   1'b0,
        reg_write:   1'b0,
        reg_write64: 1'b0,
        ir_write:    1'b1,
        adr_src:     1'b0,
        reg_src64b:  1'b0,
        alu_src_a:   SRCA_PC,
        alu_src_b:   SRCB_FOUR,
        result_src:  RES_ALURESULT,
        alu_control: ALU_ADD
    };

    // Data-processing commands this core executes
    function automatic logic cmd_supported(input logic [3:0] cmd);
        return (cmd == CMD_ADD) || (cmd == CMD_SUB) || (cmd == CMD_AND) ||
               (cmd == CMD_ORR) || (cmd == CMD_CMP);
    endfunction

    // ALU operation for a data-processing cmd; CMP is a flag-only SUB
    function automatic logic [2:0] alu_for_cmd(input logic [3:0] cmd);
        logic [2:0] op;
        op = ALU_ADD;
        case (cmd)
            CMD_SUB: op = ALU_SUB;
            CMD_CMP: op = ALU_SUB;
            CMD_AND: op = ALU_AND;
            CMD_ORR: op = ALU_ORR;
            default: op = ALU_ADD;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/mc_arm_condcheck.sv
// Condition-code evaluation: decides whether the instruction's cond field
// passes against the registered {N,Z,C,V} flags.
module mc_arm_condcheck
    import mc_arm_pkg::*;
(
    input  logic [3:0] cond,
    input  logic [3:0] flags,
    output logic       cond_ex
);

    logic n, z, c, v;

    assign n = flags[FLAG_N];
    assign z = flags[FLAG_Z];
    assign c = flags[FLAG_C];
    assign v = flags[FLAG_V];

    // Map each ARM condition to its flag expression; 1111 never executes
    always_comb begin
        cond_ex = 1'b0;
        case (cond)
            COND_EQ: cond_ex = z;
            COND_NE: cond_ex = ~z;
            COND_CS: cond_ex = c;
            COND_CC: cond_ex = ~c;
            COND_MI: cond_ex = n;
            COND_PL: cond_ex = ~n;
            COND_VS: cond_ex = v;
            COND_VC: cond_ex = ~v;
            COND_HI: cond_ex = c & ~z;
            COND_LS: cond_ex = ~c | z;
            COND_GE: cond_ex = (n == v);
            COND_LT: cond_ex = (n != v);
            COND_GT: cond_ex = ~z & (n == v);
            COND_LE: cond_ex = z | (n != v);
            COND_AL: cond_ex = 1'b1;
            default: cond_ex = 1'b0;
        endcase
    end

endmodule

// File: rtl/mc_arm_ctrl.sv
// Multicycle ARM control unit: main FSM, instruction decode, flag register
// and condition check. Datapath controls are registered from the next state
// so each one is valid for the whole cycle of the state it belongs to.
// Optional build macro MC_ARM_CTRL_LONGMUL_EN enables UMULL/SMULL; without
// it those encodings are treated as unknown instructions.
module mc_arm_ctrl
    import mc_arm_pkg::*;
#(
    parameter int unsigned FLAG_W = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [31:0]       Instr,
    input  logic [FLAG_W-1:0] ALUFlags,
    output logic              PCWrite,
    output logic              MemWrite,
    output logic              RegWrite,
    output logic              RegWrite64,
    output logic              IRWrite,
    output logic              AdrSrc,
    output logic [1:0]        RegSrc,
    output logic              RegSrc64b,
    output logic [1:0]        ALUSrcA,
    output logic [1:0]        ALUSrcB,
    output logic [1:0]        ResultSrc,
    output logic [1:0]        ImmSrc,
    output logic [2:0]        ALUControl
);

    state_t            state_q, state_d;
    logic [FLAG_W-1:0] flags_q, flags_d;
    ctrl_t             ctrl_q, ctrl_d;

    logic [3:0] cond;
    logic [1:0] op;
    logic       imm_bit;
    logic [3:0] cmd;
    logic       s_bit;
    logic       rd_is_pc;
    logic       is_mul;
    logic [2:0] mul_op;
    logic       mul_ok;
    logic [2:0] mul_alu;
    logic       cond_ex;
    logic       unused_instr_bits;

    assign cond     = Instr[31:28];
    assign op       = Instr[27:26];
    assign imm_bit  = Instr[25];
    assign cmd      = Instr[24:21];
    assign s_bit    = Instr[20];
    assign rd_is_pc = (Instr[15:12] == 4'hF);
    assign mul_op   = Instr[23:21];
    // Multiply class: register form, bit 24 clear, 1001 in bits 7:4
    assign is_mul   = ~imm_bit & ~Instr[24] & (Instr[7:4] == 4'b1001);

    assign unused_instr_bits = ^{Instr[19:16], Instr[11:8], Instr[3:0]};

    mc_arm_condcheck u_condcheck (
        .cond    (cond),
        .flags   (flags_q[3:0]),
        .cond_ex (cond_ex)
    );

    // Multiply sub-decode: which forms are accepted and their ALU operation
    always_comb begin
        mul_ok  = (mul_op == MUL_OP_MUL);
        mul_alu = ALU_MUL;
`ifdef MC_ARM_CTRL_LONGMUL_EN
        if (mul_op == MUL_OP_UMULL) begin
            mul_ok  = 1'b1;
            mul_alu = ALU_UMULL;
        end else if (mul_op == MUL_OP_SMULL) begin
            mul_ok  = 1'b1;
            mul_alu = ALU_SMULL;
        end
`endif
    end

    // Next-state logic for the main sequencer
    always_comb begin
        state_d = state_q;
        case (state_q)
            FETCH:  state_d = DECODE;
            DECODE: begin
                if (!cond_ex) begin
                    state_d = FETCH;
                end else begin
                    case (op)
                        OP_MEM:  state_d = MEMADR;
                        OP_BR:   state_d = Instr[24] ? UNKNOWN : BRANCH;
                        OP_DP: begin
                            if (imm_bit)
                                state_d = cmd_supported(cmd) ? EXECI : UNKNOWN;
                            else if (is_mul)
                                state_d = mul_ok ? MULEX : UNKNOWN;
                            else
                                state_d = cmd_supported(cmd) ? EXECR : UNKNOWN;
                        end
                        default: state_d = UNKNOWN;
                    endcase
                end
            end
            MEMADR:  state_d = s_bit ? MEMRD : MEMWR;
            MEMRD:   state_d = MEMWB;
            EXECR,
            EXECI:   state_d = (cmd == CMD_CMP) ? FETCH : ALUWB;
            MULEX:   state_d = MULWB;
            default: state_d = FETCH;
        endcase
    end

    // Flag update: data-processing with S or CMP, and MULS (N,Z only)
    always_comb begin
        flags_d = flags_q;
        case (state_q)
            EXECR,
            EXECI: begin
                if (s_bit || (cmd == CMD_CMP)) begin
                    if ((cmd == CMD_AND) || (cmd == CMD_ORR)) begin
                        flags_d[FLAG_N] = ALUFlags[FLAG_N];
                        flags_d[FLAG_Z] = ALUFlags[FLAG_Z];
                    end else begin
                        flags_d = ALUFlags;
                    end
                end
            end
            MULEX: begin
                if (s_bit) begin
                    flags_d[FLAG_N] = ALUFlags[FLAG_N];
                    flags_d[FLAG_Z] = ALUFlags[FLAG_Z];
                end
            end
            default: flags_d = flags_q;
        endcase
    end

    // Control word for the state being entered, so outputs are registered
    always_comb begin
        ctrl_d = '0;
        case (state_d)
            FETCH:  ctrl_d = CTRL_FETCH;
            DECODE: begin
                ctrl_d.alu_src_a  = SRCA_PC;
                ctrl_d.alu_src_b  = SRCB_FOUR;
                ctrl_d.result_src = RES_ALURESULT;
            end
            MEMADR: begin
                ctrl_d.alu_src_a   = SRCA_A;
                ctrl_d.alu_src_b   = SRCB_IMM;
                ctrl_d.alu_control = ALU_ADD;
            end
            MEMRD:  ctrl_d.adr_src = 1'b1;
            MEMWB: begin
                ctrl_d.result_src = RES_DATA;
                ctrl_d.reg_write  = 1'b1;
                ctrl_d.pc_write   = rd_is_pc;
            end
            MEMWR: begin
                ctrl_d.adr_src   = 1'b1;
                ctrl_d.mem_write = 1'b1;
            end
            EXECR: begin
                ctrl_d.alu_src_b   = SRCB_WD;
                ctrl_d.alu_control = alu_for_cmd(cmd);
            end
            EXECI: begin
                ctrl_d.alu_src_b   = SRCB_IMM;
                ctrl_d.alu_control = alu_for_cmd(cmd);
            end
            ALUWB: begin
                ctrl_d.result_src = RES_ALUOUT;
                ctrl_d.reg_write  = 1'b1;
                ctrl_d.pc_write   = rd_is_pc;
            end
            BRANCH: begin
                ctrl_d.alu_src_a   = SRCA_A;
                ctrl_d.alu_src_b   = SRCB_IMM;
                ctrl_d.alu_control = ALU_ADD;
                ctrl_d.result_src  = RES_ALURESULT;
                ctrl_d.pc_write    = 1'b1;
            end
            MULEX: begin
                ctrl_d.reg_src64b  = 1'b1;
                ctrl_d.alu_src_a   = SRCA_A;
                ctrl_d.alu_src_b   = SRCB_WD;
                ctrl_d.alu_control = mul_alu;
            end
            MULWB: begin
                ctrl_d.reg_src64b = 1'b1;
                ctrl_d.result_src = RES_ALUOUT;
`ifdef MC_ARM_CTRL_LONGMUL_EN
                ctrl_d.reg_write   = (mul_op == MUL_OP_MUL);
                ctrl_d.reg_write64 = (mul_op != MUL_OP_MUL);
`else
                ctrl_d.reg_write   = 1'b1;
`endif
            end
            default: ctrl_d = '0;
        endcase
    end

    // State, flags and control word; reset aborts straight to FETCH
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= FETCH;
            flags_q <= '0;
            ctrl_q  <= CTRL_FETCH;
        end else begin
            state_q <= state_d;
            flags_q <= flags_d;
            ctrl_q  <= ctrl_d;
        end
    end

    assign PCWrite    = ctrl_q.pc_write;
    assign MemWrite   = ctrl_q.mem_write;
    assign RegWrite   = ctrl_q.reg_write;
    assign RegWrite64 = ctrl_q.reg_write64;
    assign IRWrite    = ctrl_q.ir_write;
    assign AdrSrc     = ctrl_q.adr_src;
    assign RegSrc64b  = ctrl_q.reg_src64b;
    assign ALUSrcA    = ctrl_q.alu_src_a;
    assign ALUSrcB    = ctrl_q.alu_src_b;
    assign ResultSrc  = ctrl_q.result_src;
    assign ALUControl = ctrl_q.alu_control;

    // Register-port and immediate selects follow the instruction directly
    assign RegSrc = {op == OP_MEM, op == OP_BR};
    assign ImmSrc = op;

endmodule

// File: tb/tb_mc_arm_ctrl.sv
// Scoreboard bench for mc_arm_ctrl: stimulus pushes one expected control
// vector per cycle, a monitor pops and compares on the falling edge.
// Build with MC_ARM_CTRL_LONGMUL_EN to exercise the long-multiply path.
`timescale 1ns/1ps
module tb_mc_arm_ctrl;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] Instr = 32'hE000_0000;
    logic [3:0]  ALUFlags = 4'hF;

    logic       PCWrite, MemWrite, RegWrite, RegWrite64, IRWrite, AdrSrc;
    logic [1:0] RegSrc;
    logic       RegSrc64b;
    logic [1:0] ALUSrcA, ALUSrcB, ResultSrc, ImmSrc;
    logic [2:0] ALUControl;

    mc_arm_ctrl #(.FLAG_W(4)) dut (
        .clk        (clk),
        .reset      (reset),
        .Instr      (Instr),
        .ALUFlags   (ALUFlags),
        .PCWrite    (PCWrite),
        .MemWrite   (MemWrite),
        .RegWrite   (RegWrite),
        .RegWrite64 (RegWrite64),
        .IRWrite    (IRWrite),
        .AdrSrc     (AdrSrc),
        .RegSrc     (RegSrc),
        .RegSrc64b  (RegSrc64b),
        .ALUSrcA    (ALUSrcA),
        .ALUSrcB    (ALUSrcB),
        .ResultSrc  (ResultSrc),
        .ImmSrc     (ImmSrc),
        .ALUControl (ALUControl)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [31:0] instr;
        logic [19:0] exp;
        logic [19:0] care;
    } item_t;

    item_t       sb_q[$];
    int unsigned checks = 0;
    int unsigned errors = 0;
    logic [31:0] cur = 32'hE000_0000;
    logic [19:0] act;

    // {PCW,MemW,RegW,RegW64,IRW,AdrSrc,RegSrc[1:0],RegSrc64b,SrcA,SrcB,ResSrc,ImmSrc,ALUCtl}
    assign act = {PCWrite, MemWrite, RegWrite, RegWrite64, IRWrite, AdrSrc, RegSrc,
                  RegSrc64b, ALUSrcA, ALUSrcB, ResultSrc, ImmSrc, ALUControl};

    // Negative select arguments mean the field is not defined for that state
    task automatic push(input string name, input bit pcw, input bit memw, input bit regw,
                        input bit rw64, input bit irw, input bit rs64, input int adr,
                        input int srca, input int srcb, input int rsrc, input int aluc);
        item_t it;
        logic [31:0] a;
        it.name = name;
        it.instr = cur;
        it.exp = '0;
        it.care = '0;
        it.exp[19] = pcw;  it.exp[18] = memw; it.exp[17] = regw;
        it.exp[16] = rw64; it.exp[15] = irw;  it.exp[11] = rs64;
        it.care[19:15] = '1;
        it.care[11] = 1'b1;
        it.exp[13] = (cur[27:26] == 2'b01);
        it.exp[12] = (cur[27:26] == 2'b10);
        it.care[13:12] = '1;
        it.exp[4:3] = cur[27:26];
        it.care[4:3] = '1;
        if (adr >= 0)  begin a = adr;  it.exp[14]   = a[0];   it.care[14]   = 1'b1; end
        if (srca >= 0) begin a = srca; it.exp[10:9] = a[1:0]; it.care[10:9] = '1;   end
        if (srcb >= 0) begin a = srcb; it.exp[8:7]  = a[1:0]; it.care[8:7]  = '1;   end
        if (rsrc >= 0) begin a = rsrc; it.exp[6:5]  = a[1:0]; it.care[6:5]  = '1;   end
        if (aluc >= 0) begin a = aluc; it.exp[2:0]  = a[2:0]; it.care[2:0]  = '1;   end
        sb_q.push_back(it);
    endtask

    // Advance to just after the next rising edge; ALUFlags idle as noise
    task automatic tick();
        @(posedge clk);
        #1;
        ALUFlags = 4'hF;
    endtask

    task automatic push_fetch();
        push("FETCH", 1, 0, 0, 0, 1, 0, 0, 1, 2, 2, 0);
    endtask
    task automatic t_fetch();
        tick(); push_fetch();
    endtask
    task automatic t_decode(input logic [31:0] ins);
        tick(); Instr = ins; cur = ins;
        push("DECODE", 0, 0, 0, 0, 0, 0, -1, 1, 2, 2, -1);
    endtask
    task automatic t_unknown();
        tick(); push("UNKNOWN", 0, 0, 0, 0, 0, 0, -1, -1, -1, -1, -1);
    endtask
    task automatic t_branch();
        tick(); push("BRANCH", 1, 0, 0, 0, 0, 0, -1, 0, 1, 2, 0);
    endtask
    task automatic t_execr(input int aluc, input logic [3:0] fl);
        tick(); ALUFlags = fl;
        push("EXECR", 0, 0, 0, 0, 0, 0, -1, -1, 0, -1, aluc);
    endtask
    task automatic t_execi(input int aluc, input logic [3:0] fl);
        tick(); ALUFlags = fl;
        push("EXECI", 0, 0, 0, 0, 0, 0, -1, -1, 1, -1, aluc);
    endtask
    task automatic t_aluwb();
        tick(); push("ALUWB", 0, 0, 1, 0, 0, 0, -1, -1, -1, 0, -1);
    endtask
    task automatic t_memadr();
        tick(); push("MEMADR", 0, 0, 0, 0, 0, 0, -1, 0, 1, -1, 0);
    endtask
    task automatic t_memrd();
        tick(); push("MEMRD", 0, 0, 0, 0, 0, 0, 1, -1, -1, -1, -1);
    endtask
    task automatic t_memwb(input bit pcw);
        tick(); push("MEMWB", pcw, 0, 1, 0, 0, 0, -1, -1, -1, 1, -1);
    endtask
    task automatic t_memwr();
        tick(); push("MEMWR", 0, 1, 0, 0, 0, 0, 1, -1, -1, -1, -1);
    endtask
    task automatic t_mulex(input int aluc);
        tick(); push("MULEX", 0, 0, 0, 0, 0, 1, -1, 0, 0, -1, aluc);
    endtask
    task automatic t_mulwb(input bit regw, input bit rw64);
        tick(); push("MULWB", 0, 0, regw, rw64, 0, 1, -1, -1, 0, -1, -1);
    endtask

    // Monitor: one expected vector per cycle, sampled on the falling edge
    initial begin
        item_t it;
        forever begin
            @(negedge clk);
            if (sb_q.size() > 0) begin
                it = sb_q.pop_front();
                checks++;
                if (((act ^ it.exp) & it.care) != '0) begin
                    errors++;
                    $display("FAIL %s instr=%h: got %b expected %b care %b",
                             it.name, it.instr, act, it.exp, it.care);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        // Reset held three cycles, then released while still in FETCH
        repeat (3) t_fetch();
        tick(); reset = 1'b0; push_fetch();

        // ADD R1,R2,R3
        t_decode(32'hE082_1003); t_execr(0, 4'hF); t_aluwb(); t_fetch();
        // SUBS R0,R0,#1 with Z set -> flags 0100
        t_decode(32'hE250_0001); t_execi(1, 4'b0100); t_aluwb(); t_fetch();
        // BEQ taken
        t_decode(32'h0A00_0004); t_branch(); t_fetch();
        // BNE not taken
        t_decode(32'h1A00_0004); t_fetch();
        // ANDS: N,Z latch from 1011, C,V hold at 0 -> flags 1000
        t_decode(32'hE010_0001); t_execr(2, 4'b1011); t_aluwb(); t_fetch();
        // BMI taken, BCS not taken
        t_decode(32'h4A00_0000); t_branch(); t_fetch();
        t_decode(32'h2A00_0000); t_fetch();
        // CMP R0,#0 goes straight back to FETCH, flags 0010
        t_decode(32'hE350_0000); t_execi(1, 4'b0010); t_fetch();
        // BHI taken (C=1, Z=0)
        t_decode(32'h8A00_0000); t_branch(); t_fetch();
        // LDR R15,[R1]: writeback also writes the PC
        t_decode(32'hE591_F000); t_memadr(); t_memrd(); t_memwb(1'b1); t_fetch();
        // STR R2,[R1,#4]: single MemWrite cycle
        t_decode(32'hE581_2004); t_memadr(); t_memwr(); t_fetch();
        // MUL R0,R1,R2
        t_decode(32'hE000_0291); t_mulex(4); t_mulwb(1'b1, 1'b0); t_fetch();
        // UMULL
        t_decode(32'hE081_0392);
`ifdef MC_ARM_CTRL_LONGMUL_EN
        t_mulex(5); t_mulwb(1'b0, 1'b1);
`else
        t_unknown();
`endif
        t_fetch();
        // Op=11, unsupported cmd (EOR), BL, and the never condition
        t_decode(32'hEC00_0000); t_unknown(); t_fetch();
        t_decode(32'hE020_0001); t_unknown(); t_fetch();
        t_decode(32'hEB00_0000); t_unknown(); t_fetch();
        t_decode(32'hFA00_0000); t_fetch();
        // Reset asserted mid-MEMRD aborts to FETCH and clears flags
        t_decode(32'hE591_2000); t_memadr(); t_memrd();
        @(negedge clk); #1; reset = 1'b1;
        tick(); push_fetch();
        tick(); reset = 1'b0; push_fetch();
        // C was set before reset: BCS now not taken; BPL taken (N=0)
        t_decode(32'h2A00_0000); t_fetch();
        t_decode(32'h5A00_0000); t_branch(); t_fetch();

        for (int i = 0; i < 4 && sb_q.size() > 0; i++) @(negedge clk);
        #1;
        if (sb_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain: %0d entries left, expected 0", sb_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
